add_share_sched: RTL and testbench

- Scheduler that shares one dut_8bit_addr adder instance among NUM_REQ requesters.
- Picks requesters in round-robin order and runs one addition at a time.
- Before each addition, it programs the adder's offset registers (DES addresses 0x0 and 0x1) so they match that request. It then returns the sum to the requester that owns it.
- It sits between the client logic and the adder. It is the only master on the adder's operand inputs and on its DES bus.

---
 rtl/add_share_sched_if.sv | 49 ++++
 rtl/add_share_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_add_share_sched.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_share_sched_if.sv
// Bus bundle for add_share_sched: requester handshake on one side,
// operand and DES configuration ports of the shared adder on the other.
// master = the scheduler, slave = requesters plus adder.
interface add_share_sched_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  // requester side
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*WIDTH-1:0] req_offset;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_carry;
  logic                     rsp_err;
  logic                     busy;

  // adder operand side
  logic [WIDTH-1:0]         add_value_a;
  logic [WIDTH-1:0]         add_value_b;
  logic                     add_data_val;
  logic [WIDTH-1:0]         add_sum_result;
  logic                     add_sum_carry;
  logic                     add_data_ready;

  // adder DES configuration side
  logic [WIDTH-1:0]         des_value;
  logic [2:0]               des_address;
  logic                     des_req_valid;
  logic                     des_wr_rd;

  modport master (
    input  req_valid, req_a, req_b, req_offset,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_err, busy,
    output add_value_a, add_value_b, add_data_val,
    input  add_sum_result, add_sum_carry, add_data_ready,
    output des_value, des_address, des_req_valid, des_wr_rd
  );

  modport slave (
    output req_valid, req_a, req_b, req_offset,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_err, busy,
    input  add_value_a, add_value_b, add_data_val,
    output add_sum_result, add_sum_carry, add_data_ready,
    input  des_value, des_address, des_req_valid, des_wr_rd
  );
endinterface

// File: rtl/add_share_sched.sv
// add_share_sched: round-robin scheduler sharing one dut_8bit_addr among
// NUM_REQ requesters. Before each addition the adder's offset registers
// (DES addr 1 = offset value, addr 0 = enable) are rewritten only when they
// differ from the shadow copy, then the sum is routed back to its owner.
// Optional build macro ADDSCHED_TIMEOUT_EN adds a WAIT-state watchdog that
// answers with rsp_err=1 and forces the offset registers to be reprogrammed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing pending, waiting for any req_valid
// ARB      | round-robin grant, req_ready pulse, capture operands
// CFG_OFS  | DES write of the offset value (addr 1)
// CFG_CTRL | DES write of the offset enable (addr 0)
// ISSUE    | one-cycle add_data_val with captured operands
// WAIT     | waiting for add_data_ready (or watchdog expiry)
// RESP     | one-cycle rsp_valid to the granted requester
module add_share_sched #(
  parameter int WIDTH          = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  add_share_sched_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_CFG_OFS,
    ST_CFG_CTRL,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ofs;
  logic             r_tgt_en;
  logic             r_cur_en;
  logic [WIDTH-1:0] r_cur_ofs;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_found;
  logic [IDX_W-1:0] w_grant;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_sel_ofs;
  logic             w_tgt_en;
  logic             w_tmo_hit;
  int               w_idx;

`ifdef ADDSCHED_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_tmo_hit = (r_state == ST_WAIT) && !bus.add_data_ready && (r_tmo_cnt == '0);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Round-robin search upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = IDX_W'(w_idx);
      end
    end
  end

  assign w_ptr_nxt = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + IDX_W'(1);
  assign w_sel_a   = bus.req_a[int'(w_grant)*WIDTH +: WIDTH];
  assign w_sel_b   = bus.req_b[int'(w_grant)*WIDTH +: WIDTH];
  assign w_sel_ofs = bus.req_offset[int'(w_grant)*WIDTH +: WIDTH];
  assign w_tgt_en  = (w_sel_ofs != '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and all bus outputs.
  always_comb begin
    w_state_nxt       = r_state;
    bus.req_ready     = '0;
    bus.rsp_valid     = '0;
    bus.rsp_sum       = '0;
    bus.rsp_carry     = 1'b0;
    bus.rsp_err       = 1'b0;
    bus.busy          = (r_state != ST_IDLE);
    bus.add_data_val  = 1'b0;
    bus.add_value_a   = r_opa;
    bus.add_value_b   = r_opb;
    bus.des_value     = '0;
    bus.des_address   = 3'd0;
    bus.des_req_valid = 1'b0;
    bus.des_wr_rd     = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (!w_found) begin
          w_state_nxt = ST_IDLE;
        end else begin
          bus.req_ready[w_grant] = 1'b1;
          if (w_tgt_en && (w_sel_ofs != r_cur_ofs)) w_state_nxt = ST_CFG_OFS;
          else if (w_tgt_en != r_cur_en)            w_state_nxt = ST_CFG_CTRL;
          else                                      w_state_nxt = ST_ISSUE;
        end
      end
      ST_CFG_OFS: begin
        bus.des_req_valid = 1'b1;
        bus.des_address   = 3'd1;
        bus.des_value     = r_ofs;
        w_state_nxt       = (r_tgt_en != r_cur_en) ? ST_CFG_CTRL : ST_ISSUE;
      end
      ST_CFG_CTRL: begin
        bus.des_req_valid = 1'b1;
        bus.des_address   = 3'd0;
        bus.des_value[0]  = r_tgt_en;
        w_state_nxt       = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.add_data_val = 1'b1;
        bus.add_value_a  = r_a;
        bus.add_value_b  = r_b;
        w_state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.add_data_ready || w_tmo_hit) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid[r_grant] = 1'b1;
        bus.rsp_sum            = r_sum;
        bus.rsp_carry          = r_carry;
`ifdef ADDSCHED_TIMEOUT_EN
        bus.rsp_err            = r_err;
`endif
        w_state_nxt = (|bus.req_valid) ? ST_ARB : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, adder register shadows, held operands and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_ofs     <= '0;
      r_tgt_en  <= 1'b0;
      r_cur_en  <= 1'b0;
      r_cur_ofs <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
    end else begin
      if (r_state == ST_ARB && w_found) begin
        r_grant  <= w_grant;
        r_ptr    <= w_ptr_nxt;
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_ofs    <= w_sel_ofs;
        r_tgt_en <= w_tgt_en;
      end
      if (r_state == ST_CFG_OFS)  r_cur_ofs <= r_ofs;
      if (r_state == ST_CFG_CTRL) r_cur_en  <= r_tgt_en;
      if (r_state == ST_ISSUE) begin
        r_opa <= r_a;
        r_opb <= r_b;
      end
      if (r_state == ST_WAIT && bus.add_data_ready) begin
        r_sum   <= bus.add_sum_result;
        r_carry <= bus.add_sum_carry;
      end
      // A lost response leaves the adder state unknown, so force a full reprogram.
      if (w_tmo_hit) begin
        r_sum     <= '0;
        r_carry   <= 1'b0;
        r_cur_en  <= 1'b0;
        r_cur_ofs <= '0;
      end
    end
  end

`ifdef ADDSCHED_TIMEOUT_EN
  // Watchdog down-counter, loaded as WAIT is entered; terminal count at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE)                            r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
      else if (r_state == ST_WAIT && r_tmo_cnt != '0)     r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
      if (r_state == ST_WAIT && bus.add_data_ready)       r_err <= 1'b0;
      else if (w_tmo_hit)                                 r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_add_share_sched.sv
// Bench for add_share_sched: behavioural adder model with DES registers,
// directed requests, scoreboard queue drained by a forked monitor thread.
`timescale 1ns/1ps
module tb_add_share_sched;
  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    int         idx;
    logic [7:0] sum;
    logic       carry;
    logic       err;
    int         lat;
    int         i2r;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  add_share_sched_if #(.WIDTH(W), .NUM_REQ(N)) bus();

  add_share_sched #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [N-1:0] tb_v;
  logic [7:0]   tb_a [N];
  logic [7:0]   tb_b [N];
  logic [7:0]   tb_o [N];

  always_comb begin
    bus.req_valid  = tb_v;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_offset = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W]      = tb_a[i];
      bus.req_b[i*W +: W]      = tb_b[i];
      bus.req_offset[i*W +: W] = tb_o[i];
    end
  end

  // adder model: DES regs, two-cycle Data_ready after Data_val
  logic [7:0]  m_ctrl, m_ofs;
  logic        m_s1_v;
  logic [9:0]  m_s1_sum;
  logic        m_stall = 1'b0;
  logic [10:0] des_log [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl <= 8'h00;
      m_ofs <= 8'h00;
      m_s1_v <= 1'b0;
      m_s1_sum <= 10'd0;
      bus.add_data_ready <= 1'b0;
      bus.add_sum_result <= 8'h00;
      bus.add_sum_carry <= 1'b0;
    end else begin
      if (bus.des_req_valid && bus.des_wr_rd) begin
        if (bus.des_address == 3'd0) m_ctrl <= bus.des_value;
        else if (bus.des_address == 3'd1) m_ofs <= bus.des_value;
        des_log.push_back({bus.des_address, bus.des_value});
      end
      m_s1_v <= bus.add_data_val && !m_stall;
      m_s1_sum <= 10'(bus.add_value_a) + 10'(bus.add_value_b) + (m_ctrl[0] ? 10'(m_ofs) : 10'd0);
      bus.add_data_ready <= m_s1_v;
      bus.add_sum_result <= m_s1_sum[7:0];
      bus.add_sum_carry <= |m_s1_sum[9:8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   total = 0;
  int   bad = 0;
  exp_t sb [$];
  logic [10:0] des_exp [$];
  int   grant_q [$];
  int   grant_cyc = 0;
  int   issue_cyc = 0;
  int   last_rsp_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] sum, input logic carry,
                          input logic err, input int lat, input int i2r);
    exp_t e;
    e.idx = idx; e.sum = sum; e.carry = carry; e.err = err; e.lat = lat; e.i2r = i2r;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (|bus.req_ready) begin
          grant_cyc = cyc;
          grant_q.push_back(cyc);
        end
        if (bus.add_data_val) issue_cyc = cyc;
        if (|bus.rsp_valid) begin
          last_rsp_cyc = cyc;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got rsp_valid=%b required none", bus.rsp_valid);
          end else begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.idx);
            chk("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
            chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.carry));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("latency", 32'(cyc - grant_cyc), 32'(e.lat));
            chk("issue_to_rsp", 32'(cyc - issue_cyc), 32'(e.i2r));
          end
        end
      end
    end
  endtask

  task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
    int n = 0;
    tb_a[i] = a; tb_b[i] = b; tb_o[i] = o; tb_v[i] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready[i] && n < 300);
    if (!bus.req_ready[i]) chk($sformatf("grant_seen_%0d", i), 32'(bus.req_ready[i]), 32'd1);
    @(posedge clk);
    #1;
    tb_v[i] = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_des(input string nm, input int base);
    chk({nm, "_des_n"}, 32'(des_log.size() - base), 32'(des_exp.size()));
    for (int k = 0; k < des_exp.size(); k++)
      if (base + k < des_log.size()) chk({nm, "_des_w"}, 32'(des_log[base+k]), 32'(des_exp[k]));
    des_exp.delete();
  endtask

  initial begin
    int base;
    tb_v = '0;
    for (int i = 0; i < N; i++) begin
      tb_a[i] = 8'h00; tb_b[i] = 8'h00; tb_o[i] = 8'h00;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_add_data_val", 32'(bus.add_data_val), 32'd0);
    chk("rst_des_req_valid", 32'(bus.des_req_valid), 32'd0);
    chk("rst_add_value_a", 32'(bus.add_value_a), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: no offset, minimum latency
    push_exp(0, 8'h46, 1'b0, 1'b0, 4, 3);
    base = des_log.size();
    drive(0, 8'h12, 8'h34, 8'h00);
    wait_sb(50);
    chk_des("t1", base);

    // 2a: new offset needs both registers
    push_exp(1, 8'h18, 1'b0, 1'b0, 6, 3);
    base = des_log.size();
    drive(1, 8'h10, 8'h05, 8'h03);
    wait_sb(50);
    des_exp.push_back({3'd1, 8'h03});
    des_exp.push_back({3'd0, 8'h01});
    chk_des("t2a", base);

    // 2b: same offset, no reprogram
    push_exp(1, 8'h18, 1'b0, 1'b0, 4, 3);
    base = des_log.size();
    drive(1, 8'h10, 8'h05, 8'h03);
    wait_sb(50);
    chk_des("t2b", base);

    // 3: disable offset only, carry out
    push_exp(2, 8'h00, 1'b1, 1'b0, 5, 3);
    base = des_log.size();
    drive(2, 8'hFF, 8'h01, 8'h00);
    wait_sb(50);
    des_exp.push_back({3'd0, 8'h00});
    chk_des("t3", base);

    // bring the pointer round to 0
    push_exp(3, 8'h80, 1'b0, 1'b0, 4, 3);
    base = des_log.size();
    drive(3, 8'h7F, 8'h01, 8'h00);
    wait_sb(50);
    chk_des("t3b", base);

    // 4: all requesters held, back-to-back round robin 0,1,2,3,0
    push_exp(0, 8'h03, 1'b0, 1'b0, 4, 3);
    push_exp(1, 8'h52, 1'b0, 1'b0, 6, 3);
    push_exp(2, 8'h00, 1'b1, 1'b0, 4, 3);
    push_exp(3, 8'hFF, 1'b0, 1'b0, 5, 3);
    push_exp(0, 8'h03, 1'b1, 1'b0, 6, 3);
    grant_q.delete();
    base = des_log.size();
    fork
      begin
        drive(0, 8'h01, 8'h02, 8'h00);
        drive(0, 8'h80, 8'h80, 8'h03);
      end
      drive(1, 8'h20, 8'h30, 8'h02);
      drive(2, 8'hF0, 8'h0E, 8'h02);
      drive(3, 8'h55, 8'hAA, 8'h00);
    join
    wait_sb(100);
    chk("t4_grants", 32'(grant_q.size()), 32'd5);
    if (grant_q.size() > 0) chk("t4_span", 32'(last_rsp_cyc - grant_q[0]), 32'd29);
    des_exp.push_back({3'd1, 8'h02});
    des_exp.push_back({3'd0, 8'h01});
    des_exp.push_back({3'd0, 8'h00});
    des_exp.push_back({3'd1, 8'h03});
    des_exp.push_back({3'd0, 8'h01});
    chk_des("t4", base);

    // 5: reset during WAIT drops the operation
    drive(1, 8'h01, 8'h01, 8'h03);
    @(posedge clk);
    #1;
    chk("t5_busy_wait", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_add_value_a", 32'(bus.add_value_a), 32'd0);
    chk("t5_add_value_b", 32'(bus.add_value_b), 32'd0);
    chk("t5_des_req_valid", 32'(bus.des_req_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    push_exp(2, 8'h42, 1'b0, 1'b0, 4, 3);
    base = des_log.size();
    drive(2, 8'h21, 8'h21, 8'h00);
    wait_sb(50);
    chk_des("t5", base);

`ifdef ADDSCHED_TIMEOUT_EN
    // 6: adder never answers, watchdog response then full reprogram
    m_stall = 1'b1;
    push_exp(0, 8'h00, 1'b0, 1'b1, 18, 17);
    base = des_log.size();
    drive(0, 8'h33, 8'h44, 8'h00);
    wait_sb(100);
    m_stall = 1'b0;
    chk_des("t6a", base);
    push_exp(1, 8'h35, 1'b0, 1'b0, 6, 3);
    base = des_log.size();
    drive(1, 8'h10, 8'h20, 8'h05);
    wait_sb(50);
    des_exp.push_back({3'd1, 8'h05});
    des_exp.push_back({3'd0, 8'h01});
    chk_des("t6b", base);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
